// File: rtl/dram_kernel_loader.sv
// Loads one kernel BRAM bank from DRAM: issues single-beat reads and unpacks each beat into rows.
// Optional statistics outputs (stall_cycles, beat_count) are enabled by defining KER_LOADER_STATS_EN.
module dram_kernel_loader #(
   parameter int KER_NUM         = 3,
   parameter int KER_WIDTH       = 75,
   parameter int KER_HEIGHT_MAX  = 1920,
   parameter int DRAM_DATA_BITS  = 512,
   parameter int DRAM_ADDR_BITS  = 29,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [$clog2(KER_NUM)-1:0]          ker_sel,
   input  logic [$clog2(KER_HEIGHT_MAX)-1:0]   ker_base,
   input  logic [DRAM_ADDR_BITS-1:0]           dram_base,
   input  logic [$clog2(KER_HEIGHT_MAX):0]     row_count,
   output logic                                busy,
   output logic                                done,
   output logic                                err,
   output logic                                dram_rd_req,
   output logic [DRAM_ADDR_BITS-1:0]           dram_rd_addr,
   input  logic                                dram_rd_gnt,
   input  logic                                dram_rd_valid,
   output logic                                dram_rd_ready,
   input  logic [DRAM_DATA_BITS-1:0]           dram_rd_data,
   output logic [KER_NUM-1:0]                  ker_wr_en,
   output logic [$clog2(KER_HEIGHT_MAX)-1:0]   ker_wr_addr,
   output logic [KER_WIDTH-1:0]                ker_wr_data
`ifdef KER_LOADER_STATS_EN
   ,
   output logic [31:0]                         stall_cycles,
   output logic [15:0]                         beat_count
`endif
);

   localparam int SEL_W  = $clog2(KER_NUM);
   localparam int ROW_W  = $clog2(KER_HEIGHT_MAX);
   localparam int CNT_W  = ROW_W + 1;
   localparam int REQ_W  = CNT_W + 1;
   localparam int WPB    = DRAM_DATA_BITS / KER_WIDTH;
   localparam int SLOT_W = (WPB > 1) ? $clog2(WPB) : 1;
   localparam int IF_W   = $clog2(MAX_OUTSTANDING) + 1;
   localparam int USED_W = WPB * KER_WIDTH;

   typedef enum logic [1:0] {IDLE, CHECK, RUN, FIN} state_t;
   state_t state_q, state_d;

   logic [SEL_W-1:0]          cfg_sel;
   logic [ROW_W-1:0]          cfg_base;
   logic [DRAM_ADDR_BITS-1:0] cfg_dram;
   logic [CNT_W-1:0]          cfg_cnt;
   logic [CNT_W-1:0]          issued;
   logic [REQ_W-1:0]          req_rows;
   logic [REQ_W-1:0]          acc_rows;
   logic [CNT_W-1:0]          rows_written;
   logic [IF_W-1:0]           in_flight;
   logic                      ub_vld;
   logic [SLOT_W-1:0]         ub_slot;
   logic [SLOT_W-1:0]         ub_last;
   logic [USED_W-1:0]         ub_data;
   logic                      err_q;

   logic              in_run, accept_start, cfg_bad, gnt_fire, acc, wr_fire, ub_final;
   logic [REQ_W-1:0]  rows_left;
   logic [SLOT_W-1:0] beat_rows_m1;

   generate
      if (USED_W < DRAM_DATA_BITS) begin : g_unused
         logic unused_hi;
         assign unused_hi = ^dram_rd_data[DRAM_DATA_BITS-1:USED_W];
      end
   endgenerate

   assign in_run       = (state_q == RUN);
   assign accept_start = (state_q == IDLE) && start;
   assign cfg_bad      = (int'(cfg_sel) >= KER_NUM) ||
                         (REQ_W'(cfg_base) + REQ_W'(cfg_cnt) > REQ_W'(KER_HEIGHT_MAX));
   // A beat is needed while fewer rows have been requested than the load asks for.
   assign dram_rd_req  = in_run && (req_rows < REQ_W'(cfg_cnt)) &&
                         (in_flight < IF_W'(MAX_OUTSTANDING));
   assign gnt_fire     = dram_rd_req && dram_rd_gnt;
   assign ub_final     = (ub_slot == ub_last);
   assign dram_rd_ready = in_run && (!ub_vld || ub_final);
   assign acc          = dram_rd_valid && dram_rd_ready;
   assign wr_fire      = in_run && ub_vld;
   assign rows_left    = REQ_W'(cfg_cnt) - acc_rows;
   assign beat_rows_m1 = (rows_left >= REQ_W'(WPB)) ? SLOT_W'(WPB - 1) : SLOT_W'(rows_left - REQ_W'(1));

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == FIN);
   assign err          = err_q;
   assign dram_rd_addr = dram_rd_req ? cfg_dram + DRAM_ADDR_BITS'(issued) : '0;
   assign ker_wr_en    = wr_fire ? (KER_NUM'(1) << cfg_sel) : '0;
   assign ker_wr_addr  = wr_fire ? cfg_base + ROW_W'(rows_written) : '0;
   assign ker_wr_data  = wr_fire ? ub_data[KER_WIDTH*int'(ub_slot) +: KER_WIDTH] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start) state_d = CHECK;
         CHECK: state_d = (cfg_bad || cfg_cnt == '0) ? FIN : RUN;
         RUN:   if (rows_written == cfg_cnt && in_flight == '0) state_d = FIN;
         FIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control: configuration latch, request/response bookkeeping, unpack slot tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_sel      <= '0;
         cfg_base     <= '0;
         cfg_dram     <= '0;
         cfg_cnt      <= '0;
         issued       <= '0;
         req_rows     <= '0;
         acc_rows     <= '0;
         rows_written <= '0;
         in_flight    <= '0;
         ub_vld       <= 1'b0;
         ub_slot      <= '0;
         ub_last      <= '0;
         err_q        <= 1'b0;
      end else begin
         if (accept_start) begin
            cfg_sel      <= ker_sel;
            cfg_base     <= ker_base;
            cfg_dram     <= dram_base;
            cfg_cnt      <= row_count;
            issued       <= '0;
            req_rows     <= '0;
            acc_rows     <= '0;
            rows_written <= '0;
            in_flight    <= '0;
            ub_vld       <= 1'b0;
            err_q        <= 1'b0;
         end else begin
            if (gnt_fire) begin
               issued   <= issued + CNT_W'(1);
               req_rows <= req_rows + REQ_W'(WPB);
            end
            unique case ({gnt_fire, acc})
               2'b10:   in_flight <= in_flight + IF_W'(1);
               2'b01:   in_flight <= in_flight - IF_W'(1);
               default: in_flight <= in_flight;
            endcase
            if (acc) begin
               ub_vld   <= 1'b1;
               ub_slot  <= '0;
               ub_last  <= beat_rows_m1;
               acc_rows <= acc_rows + REQ_W'(beat_rows_m1) + REQ_W'(1);
            end else if (wr_fire) begin
               if (ub_final) ub_vld  <= 1'b0;
               else          ub_slot <= ub_slot + SLOT_W'(1);
            end
            if (wr_fire) rows_written <= rows_written + CNT_W'(1);
         end
         // Stray read data outside a load is flagged; setting takes priority over the start clear.
         if ((state_q == CHECK && cfg_bad) ||
             (dram_rd_valid && (state_q == IDLE || state_q == FIN)))
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (acc) ub_data <= dram_rd_data[USED_W-1:0];
   end

`ifdef KER_LOADER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         beat_count   <= '0;
      end else if (accept_start) begin
         stall_cycles <= '0;
         beat_count   <= '0;
      end else begin
         if (in_run && !wr_fire && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
         if (acc) beat_count <= beat_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dram_kernel_loader.sv
// Scoreboard bench for dram_kernel_loader: a DRAM responder, a reference row model and a write/request monitor.
module tb_dram_kernel_loader;

   localparam int KER_NUM = 3, KER_WIDTH = 75, KER_HEIGHT_MAX = 1920;
   localparam int DB = 512, AB = 29, MO = 4, WPB = DB / KER_WIDTH;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [1:0]  ker_sel = '0;
   logic [10:0] ker_base = '0;
   logic [AB-1:0] dram_base = '0;
   logic [11:0] row_count = '0;
   logic busy, done, err, dram_rd_req, dram_rd_ready;
   logic [AB-1:0] dram_rd_addr;
   logic dram_rd_gnt, dram_rd_valid;
   logic [DB-1:0] dram_rd_data;
   logic [KER_NUM-1:0] ker_wr_en;
   logic [10:0] ker_wr_addr;
   logic [KER_WIDTH-1:0] ker_wr_data;
`ifdef KER_LOADER_STATS_EN
   logic [31:0] stall_cycles;
   logic [15:0] beat_count;
`endif

   dram_kernel_loader #(.KER_NUM(KER_NUM), .KER_WIDTH(KER_WIDTH), .KER_HEIGHT_MAX(KER_HEIGHT_MAX),
                        .DRAM_DATA_BITS(DB), .DRAM_ADDR_BITS(AB), .MAX_OUTSTANDING(MO)) dut (
      .clk(clk), .rst(rst), .start(start), .ker_sel(ker_sel), .ker_base(ker_base),
      .dram_base(dram_base), .row_count(row_count), .busy(busy), .done(done), .err(err),
      .dram_rd_req(dram_rd_req), .dram_rd_addr(dram_rd_addr), .dram_rd_gnt(dram_rd_gnt),
      .dram_rd_valid(dram_rd_valid), .dram_rd_ready(dram_rd_ready), .dram_rd_data(dram_rd_data),
      .ker_wr_en(ker_wr_en), .ker_wr_addr(ker_wr_addr), .ker_wr_data(ker_wr_data)
`ifdef KER_LOADER_STATS_EN
      , .stall_cycles(stall_cycles), .beat_count(beat_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0]          addr;
      logic [KER_WIDTH-1:0] data;
      logic [KER_NUM-1:0]   en;
   } wr_t;

   wr_t           exp_wr[$];
   logic [AB-1:0] exp_req[$];
   logic [AB-1:0] pending[$];
   int  n_checks = 0, n_fail = 0;
   int  done_cnt = 0, wr_seen = 0, gnt_seen = 0;
   bit  rand_mode = 1'b0, hold_valid = 1'b0;

   function automatic logic [DB-1:0] data_of(input logic [AB-1:0] a);
      logic [DB-1:0] d;
      for (int i = 0; i < DB / 32; i++)
         d[32*i +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA6B) ^ 32'h5A5A0000;
      return d;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // DRAM side: grants requests, returns each granted beat in order, drops everything on reset
   initial begin
      bit fire_g, fire_v;
      logic [AB-1:0] ga;
      dram_rd_gnt = 1'b0; dram_rd_valid = 1'b0; dram_rd_data = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pending.delete();
            dram_rd_gnt = 1'b0;
            dram_rd_valid = 1'b0;
         end else begin
            dram_rd_gnt = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!dram_rd_valid)
               dram_rd_valid = (pending.size() > 0) && !hold_valid &&
                               (rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (dram_rd_valid) dram_rd_data = data_of(pending[0]);
            #1;
            fire_g = dram_rd_req && dram_rd_gnt;
            fire_v = dram_rd_valid && dram_rd_ready;
            ga = dram_rd_addr;
            if (fire_v) begin
               void'(pending.pop_front());
               @(negedge clk);
               dram_rd_valid = 1'b0;
               if (fire_g) pending.push_back(ga);
               #0;
               // re-enter the loop body for this same negedge
               if (!rst) begin
                  dram_rd_gnt = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
                  dram_rd_valid = (pending.size() > 0) && !hold_valid &&
                                  (rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1);
                  if (dram_rd_valid) dram_rd_data = data_of(pending[0]);
                  #1;
                  fire_g = dram_rd_req && dram_rd_gnt;
                  fire_v = dram_rd_valid && dram_rd_ready;
                  ga = dram_rd_addr;
                  if (fire_v) begin
                     void'(pending.pop_front());
                     dram_rd_valid = 1'b0;
                  end
                  if (fire_g) pending.push_back(ga);
               end else begin
                  pending.delete();
                  dram_rd_gnt = 1'b0;
               end
            end else if (fire_g) begin
               pending.push_back(ga);
            end
         end
      end
   end

   // Monitor: every granted request and every kernel write is matched against the scoreboard
   initial begin
      wr_t e;
      forever begin
         @(negedge clk); #2;
         if (done) done_cnt++;
         if (dram_rd_req && dram_rd_gnt) begin
            gnt_seen++;
            if (exp_req.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL req_extra: request at %0h, none expected", dram_rd_addr);
            end else check("req_addr", 128'(dram_rd_addr), 128'(exp_req.pop_front()));
         end
         if (ker_wr_en != '0) begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL wr_extra: write en %0h addr %0d, none expected", ker_wr_en, ker_wr_addr);
            end else begin
               e = exp_wr.pop_front();
               check("wr_en", 128'(ker_wr_en), 128'(e.en));
               check("wr_addr", 128'(ker_wr_addr), 128'(e.addr));
               check("wr_data", 128'(ker_wr_data), 128'(e.data));
            end
         end
      end
   end

   task automatic begin_load(input int sel, input int base, input logic [AB-1:0] db, input int cnt,
                             output int d0, output bit bad);
      logic [DB-1:0] beat;
      wr_t e;
      bad = (sel >= KER_NUM) || (base + cnt > KER_HEIGHT_MAX);
      @(negedge clk);
      ker_sel = 2'(sel); ker_base = 11'(base); dram_base = db; row_count = 12'(cnt);
      start = 1'b1;
      if (!bad) begin
         for (int b = 0; b * WPB < cnt; b++) exp_req.push_back(db + AB'(b));
         for (int r = 0; r < cnt; r++) begin
            beat   = data_of(db + AB'(r / WPB));
            e.data = beat[KER_WIDTH*(r % WPB) +: KER_WIDTH];
            e.addr = 11'(base + r);
            e.en   = KER_NUM'(1) << sel;
            exp_wr.push_back(e);
         end
      end
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b0;
      #3;
      check("busy_rise", 128'(busy), 128'(1));
   endtask

   task automatic finish_load(input int d0, input bit bad, input bit chk_lat);
      int t = 0;
      while (done_cnt == d0 && t < 4000) begin
         @(negedge clk); #3;
         t++;
      end
      if (done_cnt == d0) begin
         n_checks++; n_fail++;
         $display("FAIL done_timeout: no done after %0d cycles, expected a pulse", t);
      end else begin
         if (chk_lat) check("done_latency", 128'(t), 128'(1));
         check("err_at_done", 128'(err), 128'(bad));
      end
      repeat (3) @(negedge clk);
      #3;
      check("done_single", 128'(done_cnt - d0), 128'(1));
      check("busy_idle", 128'(busy), 128'(0));
      check("wr_left", 128'(exp_wr.size()), 128'(0));
      check("req_left", 128'(exp_req.size()), 128'(0));
   endtask

   task automatic load(input int sel, input int base, input logic [AB-1:0] db, input int cnt,
                       input bit chk_lat);
      int d0;
      bit bad;
      begin_load(sel, base, db, cnt, d0, bad);
      finish_load(d0, bad, chk_lat);
   endtask

   initial begin
      int d0, g0, w0, t, cnt, base;
      bit bad;
      #2;
      check("reset_outputs", 128'({busy, done, err, dram_rd_req, dram_rd_addr, dram_rd_ready,
                                    ker_wr_en, ker_wr_addr, ker_wr_data}), 128'(0));
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      load(1, 0, 29'h100, 12, 1'b0);
      load(0, 40, 29'h200, 7, 1'b0);

      hold_valid = 1'b1;
      g0 = gnt_seen;
      begin_load(2, 100, 29'h300, 60, d0, bad);
      repeat (20) @(negedge clk);
      #3;
      check("held_grants", 128'(gnt_seen - g0), 128'(MO));
      check("req_stalled", 128'(dram_rd_req), 128'(0));
      hold_valid = 1'b0;
      finish_load(d0, bad, 1'b0);

      load(3, 0, 29'h400, 10, 1'b1);
      load(0, 1900, 29'h500, 21, 1'b0);
      load(0, 1900, 29'h600, 20, 1'b0);
      load(1, 5, 29'h1FFFFFFE, 18, 1'b0);
      load(2, 0, 29'h700, 0, 1'b0);

      w0 = wr_seen;
      begin_load(2, 0, 29'h2000, 60, d0, bad);
      t = 0;
      while (wr_seen < w0 + 5 && t < 500) begin
         @(negedge clk); #3;
         t++;
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_run", 128'({busy, done, err, dram_rd_req, dram_rd_addr, dram_rd_ready,
                                  ker_wr_en, ker_wr_addr, ker_wr_data}), 128'(0));
      exp_wr.delete();
      exp_req.delete();
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      load(2, 10, 29'h3000, 6, 1'b0);

      rand_mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cnt  = $urandom_range(0, 80);
         base = ($urandom_range(0, 3) == 0) ? (KER_HEIGHT_MAX - cnt + $urandom_range(0, 2))
                                            : $urandom_range(0, 1800);
         load($urandom_range(0, 3), base, AB'($urandom), cnt, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
